// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 receiver constants and prefix FSM state type
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // start + 8 data + parity + stop
    localparam int FRAME_LEN = 11;
    localparam int BIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

endpackage

// File: rtl/ps2_fifo.sv
// rtl/ps2_fifo.sv - parametric synchronous FIFO with push/pop/full/empty
module ps2_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // a push into a full FIFO still lands when the head leaves the same cycle
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ps2_scancode_receiver.sv
// rtl/ps2_scancode_receiver.sv - PS/2 deserialiser, make/break prefix FSM and keycode FIFO
module ps2_scancode_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_down,
    output logic       key_ext,
    output logic [7:0] press_count,
    output logic       overflow,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]           clk_sync;
    logic [1:0]           data_sync;
    logic                 fall;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [FRAME_LEN-2:0] frame;
    logic [TW-1:0]        to_cnt;
    logic                 byte_valid;
    logic [7:0]           rx_byte;

    ps2_state_t           state;
    logic [7:0]           held_code;
    logic                 is_make;
    logic                 make_ext;
    logic                 is_repeat;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [7:0]           fifo_head;

    assign fall = clk_sync[2] & ~clk_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync   <= '0;
            data_sync  <= '0;
            bit_cnt    <= '0;
            frame      <= '0;
            to_cnt     <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            frame_err  <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[1:0], ps2_clk};
            data_sync  <= {data_sync[0], ps2_data};
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                if (bit_cnt == BIT_CNT_W'(FRAME_LEN - 1)) begin
                    // the stop bit is checked straight off the synchroniser
                    bit_cnt <= '0;
                    if (!frame[0] && data_sync[1] && (^frame[9:1])) begin
                        byte_valid <= 1'b1;
                        rx_byte    <= frame[8:1];
                    end else begin
                        frame_err  <= 1'b1;
                    end
                end else begin
                    frame[bit_cnt] <= data_sync[1];
                    bit_cnt        <= bit_cnt + 1'b1;
                end
            end else if (to_cnt != TW'(TIMEOUT)) begin
                to_cnt <= to_cnt + 1'b1;
            end else if (bit_cnt != '0) begin
                bit_cnt <= '0;
            end
        end
    end

    always_comb begin
        is_make  = 1'b0;
        make_ext = 1'b0;
        case (state)
            ST_IDLE: is_make = (rx_byte != PS2_EXT) && (rx_byte != PS2_BREAK);
            ST_EXT: begin
                is_make  = (rx_byte != PS2_BREAK);
                make_ext = 1'b1;
            end
            default: is_make = 1'b0;
        endcase
    end

    assign is_repeat = key_down && (rx_byte == held_code) && (key_ext == make_ext);
    assign push      = byte_valid && is_make && !is_repeat;
    assign pop       = key_valid && key_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            held_code   <= '0;
            key_down    <= 1'b0;
            key_ext     <= 1'b0;
            press_count <= '0;
            overflow    <= 1'b0;
        end else if (byte_valid) begin
            case (state)
                ST_IDLE: begin
                    if (rx_byte == PS2_EXT)
                        state <= ST_EXT;
                    else if (rx_byte == PS2_BREAK)
                        state <= ST_BRK;
                end
                ST_EXT:
                    state <= (rx_byte == PS2_BREAK) ? ST_EXT_BRK : ST_IDLE;
                default: begin
                    state <= ST_IDLE;
                    if (rx_byte == held_code) begin
                        key_down <= 1'b0;
                        key_ext  <= 1'b0;
                    end
                end
            endcase
            if (push) begin
                held_code   <= rx_byte;
                key_down    <= 1'b1;
                key_ext     <= make_ext;
                press_count <= press_count + 1'b1;
                if (fifo_full && !pop)
                    overflow <= 1'b1;
            end
        end
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (rx_byte),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign key_valid = !fifo_empty;
    assign keycode   = key_valid ? fifo_head : 8'h00;

endmodule
